// File: rtl/andla_rf_scoreboard.sv
// Regfile write scoreboard: per-item outstanding launch counters, write back-pressure,
// sfence stalls and the command-completion interrupt FSM.
module andla_rf_scoreboard #(
  parameter int unsigned ITEM_ID_NUM       = 8,
  parameter int unsigned ITEM_ID_BITWIDTH  = 3,
  parameter int unsigned INDEX_BITWIDTH    = 5,
  parameter int unsigned RF_ADDR_BITWIDTH  = 8,
  parameter int unsigned RF_WDATA_BITWIDTH = 32,
  parameter int unsigned CSR_ID            = 0,
  parameter int unsigned TRIG_INDEX        = 0,
  parameter int unsigned FENCE_INDEX       = 1,
  parameter int unsigned INTR_INDEX        = 2,
  parameter int unsigned MAX_OUTSTANDING   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RF_ADDR_BITWIDTH-1:0]  issue_rf_riurwaddr,
  input  logic                         issue_rf_riuwe,
  input  logic [RF_WDATA_BITWIDTH-1:0] issue_rf_riuwdata,
  output logic                         issue_rf_riuwstatus,
  output logic                         wr_taken,
  input  logic [ITEM_ID_NUM-1:0]       ip_rf_status_clr,
  output logic [ITEM_ID_NUM-1:0]       rf_item_busy,
  output logic                         rf_block_intr,
  output logic [ITEM_ID_NUM-1:0]       rf_sb_err
);

  localparam int unsigned OUT_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PEND  = 2'd2
  } intr_state_e;

  intr_state_e                  state, state_next;
  logic [OUT_CNT_W-1:0]         cnt      [ITEM_ID_NUM];
  logic [OUT_CNT_W-1:0]         cnt_next [ITEM_ID_NUM];
  logic [ITEM_ID_NUM-1:0]       err_next;
  logic [ITEM_ID_NUM-1:0]       busy_next;
  logic [ITEM_ID_NUM-1:0]       launch_vec;
  logic [ITEM_ID_NUM-1:0]       csr_bit;
  logic [ITEM_ID_BITWIDTH-1:0]  item;
  logic [INDEX_BITWIDTH-1:0]    index;
  logic                         is_csr;
  logic                         is_fence;
  logic                         is_icmd;
  logic                         item_full;
  logic                         intr_armed;
  logic                         fence_block;
  logic                         launch;
  logic                         icmd_taken;
  logic                         all_idle;
  logic                         unused_bits;

  assign item    = issue_rf_riurwaddr[RF_ADDR_BITWIDTH-1 -: ITEM_ID_BITWIDTH];
  assign index   = issue_rf_riurwaddr[INDEX_BITWIDTH-1:0];
  assign csr_bit = ITEM_ID_NUM'(1) << CSR_ID;

  assign is_csr   = (item == ITEM_ID_BITWIDTH'(CSR_ID));
  assign is_fence = is_csr & (index == INDEX_BITWIDTH'(FENCE_INDEX));
  assign is_icmd  = is_csr & (index == INDEX_BITWIDTH'(INTR_INDEX));

  // Addressed item already holds the maximum number of in-flight launches
  always_comb begin
    item_full = 1'b0;
    for (int i = 0; i < int'(ITEM_ID_NUM); i++) begin
      if ((item == ITEM_ID_BITWIDTH'(i)) && (cnt[i] == OUT_CNT_W'(MAX_OUTSTANDING))) begin
        item_full = 1'b1;
      end
    end
  end

  assign intr_armed  = (state != IDLE);
  assign fence_block = is_fence &
                       (|(issue_rf_riuwdata[ITEM_ID_NUM-1:0] & rf_item_busy & ~csr_bit));

  assign issue_rf_riuwstatus = issue_rf_riuwe &
                               ((~is_csr & (intr_armed | item_full)) | fence_block);
  assign wr_taken   = issue_rf_riuwe & ~issue_rf_riuwstatus;
  assign launch     = wr_taken & ~is_csr & (index == INDEX_BITWIDTH'(TRIG_INDEX));
  assign icmd_taken = wr_taken & is_icmd;
  assign all_idle   = ~|(rf_item_busy & ~csr_bit);

  // Counter, busy and sticky-error next values; launch and clear together cancel out
  always_comb begin
    err_next = rf_sb_err;
    for (int i = 0; i < int'(ITEM_ID_NUM); i++) begin
      cnt_next[i]   = cnt[i];
      launch_vec[i] = launch & (item == ITEM_ID_BITWIDTH'(i));
      if (i != int'(CSR_ID)) begin
        if (launch_vec[i] && !ip_rf_status_clr[i]) begin
          cnt_next[i] = cnt[i] + OUT_CNT_W'(1);
        end else if (!launch_vec[i] && ip_rf_status_clr[i]) begin
          if (cnt[i] == '0) begin
            err_next[i] = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] - OUT_CNT_W'(1);
          end
        end
      end
      busy_next[i] = (cnt_next[i] != '0);
    end
  end

  // Interrupt FSM next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (icmd_taken && issue_rf_riuwdata[0]) state_next = ARMED;
      end
      ARMED: begin
        if (icmd_taken && issue_rf_riuwdata[1]) state_next = IDLE;
        else if (all_idle)                      state_next = PEND;
      end
      PEND: begin
        if (icmd_taken && issue_rf_riuwdata[1]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rf_item_busy  <= '0;
      rf_sb_err     <= '0;
      rf_block_intr <= 1'b0;
      for (int i = 0; i < int'(ITEM_ID_NUM); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state         <= state_next;
      rf_item_busy  <= busy_next;
      rf_sb_err     <= err_next;
      rf_block_intr <= (state_next == PEND);
      for (int i = 0; i < int'(ITEM_ID_NUM); i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Upper data bits and the CSR clear bit carry no meaning here
  assign unused_bits = ^{issue_rf_riuwdata, ip_rf_status_clr[CSR_ID]};

endmodule

// File: tb/tb_andla_rf_scoreboard.sv
// Self-checking bench for andla_rf_scoreboard: directed scenarios plus randomized traffic,
// all checked each cycle against a count/mode based reference model.
module tb_andla_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic        stall;
  logic        taken;
  logic [7:0]  clr;
  logic [7:0]  busy;
  logic        intr;
  logic [7:0]  err;

  andla_rf_scoreboard dut (
    .clk                 (clk),
    .rst                 (rst),
    .issue_rf_riurwaddr  (addr),
    .issue_rf_riuwe      (we),
    .issue_rf_riuwdata   (wdata),
    .issue_rf_riuwstatus (stall),
    .wr_taken            (taken),
    .ip_rf_status_clr    (clr),
    .rf_item_busy        (busy),
    .rf_block_intr       (intr),
    .rf_sb_err           (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: outstanding count per item, sticky errors, interrupt mode 0/1/2 = idle/armed/pending
  int         m_cnt [8];
  logic [7:0] m_err;
  int         m_mode;
  logic       last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_busy();
    logic [7:0] b = 8'h00;
    for (int i = 1; i < 8; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  // One clock: compare at the falling edge, advance the model across the rising edge
  task automatic tick();
    logic [2:0] it;
    logic [4:0] ix;
    logic       csr, st, tk, idle, ln;
    logic [7:0] bm;
    int         nc [8];
    logic [7:0] ne;
    int         nm;
    @(negedge clk);
    it  = addr[7:5];
    ix  = addr[4:0];
    csr = (it == 3'd0);
    bm  = model_busy();
    st  = we && ((!csr && m_mode != 0) || (!csr && m_cnt[it] == 2) ||
                 (csr && ix == 5'd1 && (wdata[7:0] & bm) != 8'h00));
    tk  = we && !st;
    chk("stall", 32'(stall), 32'(st));
    chk("wr_taken", 32'(taken), 32'(tk));
    chk("busy", 32'(busy), 32'(bm));
    chk("sb_err", 32'(err), 32'(m_err));
    chk("intr", 32'(intr), 32'(m_mode == 2));
    last_stall = st;
    ne = m_err;
    nm = m_mode;
    for (int i = 0; i < 8; i++) nc[i] = m_cnt[i];
    if (rst) begin
      for (int i = 0; i < 8; i++) nc[i] = 0;
      ne = 8'h00;
      nm = 0;
    end else begin
      idle = (bm == 8'h00);
      for (int i = 1; i < 8; i++) begin
        ln = tk && !csr && ix == 5'd0 && int'(it) == i;
        if (ln && !clr[i]) nc[i] = m_cnt[i] + 1;
        else if (!ln && clr[i]) begin
          if (m_cnt[i] == 0) ne[i] = 1'b1;
          else nc[i] = m_cnt[i] - 1;
        end
      end
      if (tk && csr && ix == 5'd2) begin
        if (m_mode == 0 && wdata[0]) nm = 1;
        else if (m_mode != 0 && wdata[1]) nm = 0;
      end
      if (m_mode == 1 && nm == 1 && idle) nm = 2;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) m_cnt[i] = nc[i];
    m_err  = ne;
    m_mode = nm;
  endtask

  task automatic wr(input int it, input int ix, input logic [31:0] d);
    we    = 1'b1;
    addr  = {3'(it), 5'(ix)};
    wdata = d;
  endtask

  task automatic pulse_clr(input logic [7:0] m);
    clr = m;
    tick();
    clr = 8'h00;
  endtask

  initial begin
    logic [2:0] it;
    logic [4:0] ix;
    logic [31:0] d;
    int sel;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_err = 8'h00;
    m_mode = 0;
    last_stall = 1'b0;
    rst = 1'b1; we = 1'b0; addr = 8'h00; wdata = 32'h0; clr = 8'h00;
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_intr", 32'(intr), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    // Item 3 fills up; third launch held until one completion
    wr(3, 0, 32'h0); tick(); tick();
    #1; chk("full_stall", 32'(stall), 32'h1); chk("full_not_taken", 32'(taken), 32'h0);
    tick();
    chk("full_busy3", 32'(busy[3]), 32'h1);
    clr = 8'h08; tick(); clr = 8'h00;
    #1; chk("held_taken", 32'(taken), 32'h1);
    tick();
    chk("busy3_kept", 32'(busy[3]), 32'h1);
    we = 1'b0;

    // Launch and completion in the same cycle cancel
    wr(5, 0, 32'h0); tick();
    clr = 8'h20; tick(); clr = 8'h00; we = 1'b0;
    chk("cancel_busy5", 32'(busy[5]), 32'h1);
    chk("cancel_err5", 32'(err[5]), 32'h0);
    pulse_clr(8'h28);
    pulse_clr(8'h08);
    chk("drained", 32'(busy), 32'h0);

    // Fence waits for masked busy items
    wr(1, 0, 32'h0); tick();
    wr(4, 0, 32'h0); tick();
    wr(0, 1, 32'h12); #1; chk("fence_stall", 32'(stall), 32'h1);
    tick();
    clr = 8'h02; tick();
    clr = 8'h10; #1; chk("fence_stall_b4", 32'(stall), 32'h1);
    tick(); clr = 8'h00;
    #1; chk("fence_release", 32'(taken), 32'h1);
    tick();
    wr(0, 1, 32'h04); #1; chk("fence_idle_taken", 32'(taken), 32'h1);
    tick(); we = 1'b0;

    // Interrupt: arm with item 6 busy, IP writes blocked, CSR writes pass
    wr(6, 0, 32'h0); tick();
    wr(0, 2, 32'h1); tick();
    wr(2, 0, 32'h0); #1; chk("armed_ip_stall", 32'(stall), 32'h1);
    tick();
    wr(0, 5, 32'hAB); #1; chk("armed_csr_taken", 32'(taken), 32'h1);
    tick(); we = 1'b0;
    pulse_clr(8'h40);
    chk("intr_not_yet", 32'(intr), 32'h0);
    tick();
    chk("intr_set", 32'(intr), 32'h1);
    wr(0, 2, 32'h2); tick();
    chk("intr_cleared", 32'(intr), 32'h0);
    wr(2, 0, 32'h0); #1; chk("after_clear_taken", 32'(taken), 32'h1);
    tick(); we = 1'b0;
    pulse_clr(8'h04);

    // Underflow is sticky
    pulse_clr(8'h80);
    chk("underflow_err7", 32'(err[7]), 32'h1);
    chk("underflow_busy7", 32'(busy[7]), 32'h0);
    tick();
    chk("err7_sticky", 32'(err[7]), 32'h1);

    // Reset while a write is held
    wr(3, 0, 32'h0); tick(); tick();
    #1; chk("pre_rst_stall", 32'(stall), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_intr", 32'(intr), 32'h0);
    #1; chk("rst_stall_drop", 32'(stall), 32'h0);
    tick(); we = 1'b0;

    // Randomized traffic; a stalled write is usually held, occasionally abandoned
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (!(we && last_stall && $urandom_range(0, 7) != 0)) begin
        if ($urandom_range(0, 1) == 1) begin
          it = 3'($urandom_range(0, 7));
          if (it == 3'd0) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) ix = 5'd1;
            else if (sel == 1) ix = 5'd2;
            else ix = 5'd5;
          end else if ($urandom_range(0, 3) != 0) begin
            ix = 5'd0;
          end else begin
            ix = 5'($urandom_range(1, 31));
          end
          d = $urandom;
          if (it == 3'd0 && ix == 5'd2) d = 32'($urandom_range(1, 2));
          wr(int'(it), int'(ix), d);
        end else begin
          we = 1'b0;
        end
      end
      if ($urandom_range(0, 15) == 0) clr = 8'($urandom);
      else clr = 8'($urandom) & model_busy();
      tick();
    end
    rst = 1'b0; we = 1'b0; clr = 8'h00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
